// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants used by fetch, the prefetch queue and decode.
// Bubble encoding: all-zero instruction at PC 0, same as the pipeline NOP.
// The fetch_entry_t pair is the unit carried from fetch to decode.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSN  = 32'h0;
  localparam logic [31:0] BUBBLE_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch/execute/decode and the prefetch queue.
// master: the pipeline side (drives enq_*, stall, flush; observes head and status).
// slave:  the queue (accepts enq_*, presents head entry and occupancy status).
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INSN_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              enq_valid;
  logic [PC_W-1:0]   enq_pc;
  logic [INSN_W-1:0] enq_insn;
  logic              enq_ready;
  logic              stall;
  logic              flush;
  logic [PC_W-1:0]   pc_out;
  logic [INSN_W-1:0] insn_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output enq_valid, enq_pc, enq_insn, stall, flush,
    input  enq_ready, pc_out, insn_out, valid_out, full, empty, count
  );

  modport slave (
    input  enq_valid, enq_pc, enq_insn, stall, flush,
    output enq_ready, pc_out, insn_out, valid_out, full, empty, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: circular buffer of {pc, insn} between fetch and decode.
// Latency: push visible at the head one cycle later (no bypass); 1 push + 1 pop per cycle.
// Backpressure: enq_ready = !full (no same-cycle refill on pop); stall holds the head;
// flush drops every entry and any same-cycle push.
// Ports: clock, reset (async, active-high), io (fetch_queue_if.slave).
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INSN_W = 32
) (
  input  logic         clock,
  input  logic         reset,
  fetch_queue_if.slave io
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full_w;
  logic             empty_w;
  logic             push;
  logic             pop;

  // Status is decoded from the registered count only.
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // Flush dominates both push and pop; stall only blocks pop.
  assign push = io.enq_valid & ~full_w & ~io.flush;
  assign pop  = ~empty_w & ~io.stall & ~io.flush;

  // DEPTH is a power of two, so the pointers wrap on their natural width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (io.flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is deliberately left out of reset; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr].pc   <= io.enq_pc;
      mem[wr_ptr].insn <= io.enq_insn;
    end
  end

  // Show-ahead head: stored entry when occupied, otherwise the pipeline bubble.
  assign io.pc_out    = empty_w ? PC_W'(BUBBLE_PC)  : mem[rd_ptr].pc;
  assign io.insn_out  = empty_w ? INSN_W'(NOP_INSN) : mem[rd_ptr].insn;
  assign io.valid_out = ~empty_w;
  assign io.full      = full_w;
  assign io.empty     = empty_w;
  assign io.count     = count_q;
  assign io.enq_ready = ~full_w;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int PC_W   = 32;
  localparam int INSN_W = 32;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INSN_W(INSN_W)) ifc();
  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INSN_W(INSN_W)) dut (
    .clock(clock),
    .reset(reset),
    .io(ifc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  // Reference model: an ordered list of queued entries plus a log of popped ones.
  ent_t mq[$];
  ent_t popped[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] exp_pc();
    return (mq.size() > 0) ? mq[0].pc : 32'h0;
  endfunction

  function automatic logic [31:0] exp_insn();
    return (mq.size() > 0) ? mq[0].insn : 32'h0;
  endfunction

  function automatic logic [CNT_W-1:0] exp_count();
    return CNT_W'(mq.size());
  endfunction

  // Apply one cycle of inputs (called at negedge), advance one clock, update model.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                      input logic st, input logic fl);
    bit   can_push;
    bit   can_pop;
    ent_t e;
    ifc.enq_valid = v;
    ifc.enq_pc    = pc;
    ifc.enq_insn  = insn;
    ifc.stall     = st;
    ifc.flush     = fl;
    can_push = v && (mq.size() < DEPTH) && !fl;
    can_pop  = (mq.size() > 0) && !st && !fl;
    @(posedge clock);
    if (fl) begin
      mq.delete();
    end else begin
      if (can_pop) popped.push_back(mq.pop_front());
      if (can_push) begin
        e.pc   = pc;
        e.insn = insn;
        mq.push_back(e);
      end
    end
    @(negedge clock);
    ifc.enq_valid = 1'b0;
    ifc.flush     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.enq_valid = 1'b0; ifc.enq_pc = '0; ifc.enq_insn = '0;
    ifc.stall = 1'b0; ifc.flush = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (ifc.count !== '0 || ifc.empty !== 1'b1 || ifc.full !== 1'b0) begin
      errors++; $display("FAIL reset_status count=%0d empty=%b full=%b want 0/1/0", ifc.count, ifc.empty, ifc.full);
    end
    checks++; if (ifc.valid_out !== 1'b0 || ifc.enq_ready !== 1'b1 || ifc.pc_out !== 32'h0 || ifc.insn_out !== 32'h0) begin
      errors++; $display("FAIL reset_outputs valid=%b rdy=%b pc=%h insn=%h want 0/1/0/0",
                         ifc.valid_out, ifc.enq_ready, ifc.pc_out, ifc.insn_out);
    end
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic test_first_push();
    step(1'b1, 32'h80020000, 32'h8FA40000, 1'b0, 1'b0);
    checks++; if (ifc.pc_out !== 32'h80020000 || ifc.insn_out !== 32'h8FA40000) begin
      errors++; $display("FAIL first_head pc=%h insn=%h want 80020000/8fa40000", ifc.pc_out, ifc.insn_out);
    end
    checks++; if (ifc.valid_out !== 1'b1 || ifc.count !== CNT_W'(1)) begin
      errors++; $display("FAIL first_status valid=%b count=%0d want 1/1", ifc.valid_out, ifc.count);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++; if (ifc.count !== '0 || ifc.valid_out !== 1'b0) begin
      errors++; $display("FAIL first_pop count=%0d valid=%b want 0/0", ifc.count, ifc.valid_out);
    end
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h80020000 + 32'(4 * i), $urandom, 1'b1, 1'b0);
    checks++; if (ifc.full !== 1'b1 || ifc.count !== CNT_W'(4) || ifc.enq_ready !== 1'b0) begin
      errors++; $display("FAIL fill_status full=%b count=%0d rdy=%b want 1/4/0", ifc.full, ifc.count, ifc.enq_ready);
    end
    step(1'b1, 32'h80020010, 32'hDEADBEEF, 1'b1, 1'b0);
    checks++; if (ifc.count !== CNT_W'(4) || ifc.pc_out !== 32'h80020000) begin
      errors++; $display("FAIL fill_reject count=%0d pc=%h want 4/80020000", ifc.count, ifc.pc_out);
    end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (ifc.pc_out !== 32'h80020000 + 32'(4 * i) || ifc.insn_out !== exp_insn()) begin
        errors++; $display("FAIL fill_order pc=%h insn=%h want %h/%h", ifc.pc_out, ifc.insn_out,
                           32'h80020000 + 32'(4 * i), exp_insn());
      end
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    checks++; if (ifc.empty !== 1'b1) begin
      errors++; $display("FAIL fill_drain empty=%b want 1", ifc.empty);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] base = 32'h80030000;
    step(1'b1, base, $urandom, 1'b1, 1'b0);
    step(1'b1, base + 32'h4, $urandom, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, base + 32'(4 * (k + 2)), $urandom, 1'b0, 1'b0);
      checks++; if (ifc.count !== CNT_W'(2) || ifc.pc_out !== base + 32'(4 * (k + 1)) || ifc.insn_out !== exp_insn()) begin
        errors++; $display("FAIL b2b_cycle%0d count=%0d pc=%h want 2/%h", k, ifc.count, ifc.pc_out,
                           base + 32'(4 * (k + 1)));
      end
    end
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++; if (popped.size() < 12 || popped[popped.size() - 1].pc !== base + 32'(4 * 11) || ifc.empty !== 1'b1) begin
      errors++; $display("FAIL b2b_drain empty=%b want 1 after 12 pops", ifc.empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h80020020 + 32'(4 * i), $urandom, 1'b1, 1'b0);
    checks++; if (ifc.count !== CNT_W'(3)) begin
      errors++; $display("FAIL flush_pre count=%0d want 3", ifc.count);
    end
    step(1'b1, 32'h80020040, 32'h12345678, 1'b0, 1'b1);
    checks++; if (ifc.count !== '0 || ifc.valid_out !== 1'b0 || ifc.insn_out !== 32'h0 || ifc.pc_out !== 32'h0) begin
      errors++; $display("FAIL flush_post count=%0d valid=%b insn=%h pc=%h want 0/0/0/0",
                         ifc.count, ifc.valid_out, ifc.insn_out, ifc.pc_out);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++; if (ifc.valid_out !== 1'b0 || ifc.pc_out === 32'h80020040) begin
        errors++; $display("FAIL flush_ghost valid=%b pc=%h want 0/00000000", ifc.valid_out, ifc.pc_out);
      end
    end
  endtask

  task automatic test_stall_empty();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (ifc.pc_out !== 32'h0 || ifc.insn_out !== 32'h0 || ifc.valid_out !== 1'b0) begin
      errors++; $display("FAIL stall_empty pc=%h insn=%h valid=%b want 0/0/0", ifc.pc_out, ifc.insn_out, ifc.valid_out);
    end
    step(1'b1, 32'h80020010, 32'hA5A50010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (ifc.pc_out !== 32'h80020010 || ifc.insn_out !== 32'hA5A50010 || ifc.count !== CNT_W'(1)) begin
        errors++; $display("FAIL stall_hold%0d pc=%h insn=%h count=%0d want 80020010/a5a50010/1",
                           i, ifc.pc_out, ifc.insn_out, ifc.count);
      end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++; if (ifc.empty !== 1'b1) begin
      errors++; $display("FAIL stall_release empty=%b want 1", ifc.empty);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h80050000 + 32'(4 * i), $urandom, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++; if (ifc.empty !== 1'b1 || ifc.count !== '0 || ifc.pc_out !== 32'h0 || ifc.enq_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset empty=%b count=%0d pc=%h rdy=%b want 1/0/0/1",
                         ifc.empty, ifc.count, ifc.pc_out, ifc.enq_ready);
    end
    mq.delete();
    @(negedge clock);
    reset = 1'b0;
    test_first_push();
  endtask

  task automatic test_random();
    logic        v = 1'b0;
    logic        st, fl;
    logic [31:0] pc = 32'h0;
    logic [31:0] insn = 32'h0;
    for (int n = 0; n < 400; n++) begin
      // A rejected entry is held stable, as fetch would.
      if (!(v && mq.size() >= DEPTH)) begin
        v    = ($urandom_range(3) != 0);
        pc   = $urandom;
        insn = $urandom;
      end
      st = ($urandom_range(2) == 0);
      fl = ($urandom_range(19) == 0);
      step(v, pc, insn, st, fl);
      if (fl) v = 1'b0;
      checks++; if (ifc.pc_out !== exp_pc() || ifc.insn_out !== exp_insn() || ifc.count !== exp_count() ||
                    ifc.valid_out !== (mq.size() > 0) || ifc.full !== (mq.size() == DEPTH) ||
                    ifc.empty !== (mq.size() == 0) || ifc.enq_ready !== (mq.size() < DEPTH)) begin
        errors++; $display("FAIL random%0d pc=%h insn=%h count=%0d want %h/%h/%0d", n,
                           ifc.pc_out, ifc.insn_out, ifc.count, exp_pc(), exp_insn(), exp_count());
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill_stall();
    test_back_to_back();
    test_flush();
    test_stall_empty();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
